// File: rtl/div_pkg.sv
// Shared types for the iterative RV32M divider: operation codes, FSM states
// and small operation-class helpers.
package div_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational W-bit subtractor (a + ~b + 1) built from 4-bit carry-lookahead
// groups; borrow is the inverted carry-out.
module div_trial_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  localparam int NG = (W + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] bn_pad;
  logic [PW-1:0] gen_w;
  logic [PW-1:0] prop_w;
  logic [NG-1:0] grp_gen;
  logic [NG-1:0] grp_prop;
  logic [NG:0]   grp_carry;
  logic [W-1:0]  bit_carry;

  // Zero-extended operands make the pad bits pure propagate, so the group
  // carry-out at the top still reflects a >= b over the real W bits.
  assign a_pad  = PW'(a_i);
  assign bn_pad = ~PW'(b_i);
  assign gen_w  = a_pad & bn_pad;
  assign prop_w = a_pad ^ bn_pad;

  always_comb begin
    grp_gen  = '0;
    grp_prop = '0;
    for (int grp = 0; grp < NG; grp++) begin
      grp_gen[grp] = gen_w[4*grp+3]
                   | (prop_w[4*grp+3] & gen_w[4*grp+2])
                   | (prop_w[4*grp+3] & prop_w[4*grp+2] & gen_w[4*grp+1])
                   | (prop_w[4*grp+3] & prop_w[4*grp+2] & prop_w[4*grp+1] & gen_w[4*grp]);
      grp_prop[grp] = &prop_w[4*grp +: 4];
    end
  end

  always_comb begin
    grp_carry    = '0;
    grp_carry[0] = 1'b1;
    for (int grp = 0; grp < NG; grp++) begin
      grp_carry[grp+1] = grp_gen[grp] | (grp_prop[grp] & grp_carry[grp]);
    end
  end

  always_comb begin
    bit_carry = '0;
    diff_o    = '0;
    for (int i = 0; i < W; i++) begin
      bit_carry[i] = grp_carry[i/4];
      for (int j = (i/4)*4; j < i; j++) begin
        bit_carry[i] = gen_w[j] | (prop_w[j] & bit_carry[i]);
      end
      diff_o[i] = prop_w[i] ^ bit_carry[i];
    end
  end

  assign borrow_o = ~grp_carry[NG];

endmodule

// File: rtl/div_seq_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// clock, valid/ready on both the request and result side.
//
//   state | meaning
//   IDLE  | o_ready high, waiting for a request
//   CALC  | XLEN shift/trial-subtract iterations on operand magnitudes
//   DONE  | o_valid high, sign-fixed result held until i_ready
module div_seq_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;

  div_op_e         in_op;
  logic            in_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial_diff;
  logic            trial_borrow;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, dvd_next;
  logic [XLEN-1:0] fixed_res;

  assign in_op     = div_op_e'(i_op);
  assign in_signed = op_is_signed(in_op);
  assign a_neg     = in_signed & i_a[XLEN-1];
  assign b_neg     = in_signed & i_b[XLEN-1];
  assign a_mag     = a_neg ? (~i_a + XLEN'(1)) : i_a;
  assign b_mag     = b_neg ? (~i_b + XLEN'(1)) : i_b;

  assign b_zero      = (i_b == '0);
  assign ovf         = in_signed && (i_a == MIN_VAL) && (i_b == '1);
  assign special     = b_zero || ovf;
  assign special_res = op_is_rem(in_op) ? (b_zero ? i_a : '0)
                                        : (b_zero ? '1 : MIN_VAL);

  assign rem_shift = {rem_q, dvd_q[XLEN-1]};

  div_trial_sub #(.W(XLEN + 1)) u_trial_sub (
    .a_i      (rem_shift),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // A non-negative trial is always below dvs, so its MSB is zero; a set MSB
  // is treated like a borrow so the kept remainder always fits XLEN bits.
  assign q_bit    = ~trial_borrow & ~trial_diff[XLEN];
  assign rem_next = q_bit ? trial_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign dvd_next = {dvd_q[XLEN-2:0], q_bit};

  always_comb begin
    fixed_res = '0;
    if (op_is_rem(op_q)) begin
      fixed_res = rem_neg_q ? (~rem_next + XLEN'(1)) : rem_next;
    end else begin
      fixed_res = quo_neg_q ? (~dvd_next + XLEN'(1)) : dvd_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d      = in_op;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = CW'(XLEN - 1);
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = fixed_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

endmodule
